sram_responder: RTL

//  Memory-side end of the CPU's asynchronous-SRAM style bus (CE/OE/WE/UB/LB active-low, ADDR, shared Data).

---
 rtl/sram_responder_if.sv | 40 ++++
 rtl/sram_responder.sv | 117 +++++++++++
 2 files changed

// File: rtl/sram_responder_if.sv
// Board-level asynchronous-SRAM style bus between the CPU and the memory responder,
// plus the loader handshake used to preload program memory.
interface sram_responder_if;
    logic        CE;
    logic        OE;
    logic        WE;
    logic        UB;
    logic        LB;
    logic [19:0] ADDR;

    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        load_ready;

    logic        rd_valid;
    logic        load_ovf;
    logic        serving;

    logic [15:0] rsp_data;
    logic        rsp_oe;
    logic [15:0] cpu_data;
    logic        cpu_oe;

    // The shared Data bus is resolved here so each side only supplies a value and an enable.
    wire  [15:0] Data;
    assign Data = (rsp_oe | cpu_oe) ? (rsp_oe ? rsp_data : cpu_data) : 16'hzzzz;

    modport master (
        output CE, OE, WE, UB, LB, ADDR, cpu_data, cpu_oe,
        output load_valid, load_data, load_last,
        input  Data, load_ready, rd_valid, load_ovf, serving, rsp_oe
    );

    modport slave (
        input  CE, OE, WE, UB, LB, ADDR, Data,
        input  load_valid, load_data, load_last,
        output load_ready, rd_valid, load_ovf, serving, rsp_data, rsp_oe
    );
endinterface

// File: rtl/sram_responder.sv
// Memory-side responder for the CPU's SRAM-style bus: preloaded through a valid/ready
// loader, then answers reads after READ_LAT wait states and commits byte-lane writes.
module sram_responder #(
    parameter int AW       = 10,
    parameter int READ_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_responder_if.slave   bus
);
    localparam int         DEPTH = 1 << AW;
    localparam logic [2:0] LAT   = 3'(READ_LAT);

    typedef enum logic {
        LOAD,
        SERVE
    } state_t;

    state_t         state;
    logic [AW-1:0]  load_ptr;
    logic [2:0]     lat_cnt;
    logic [2:0]     lat_nxt;
    logic [19:0]    rd_addr;
    logic           rd_valid_r;
    logic           load_ready_r;
    logic           load_ovf_r;
    logic           serving_r;
    logic [15:0]    mem [DEPTH];

    logic           wr_req;
    logic           rd_req;
    logic [AW-1:0]  wr_word;
    logic [AW-1:0]  rd_word;
    logic [15:0]    rd_word_data;

    assign wr_req  = !bus.CE && !bus.WE;
    assign rd_req  = !bus.CE && !bus.OE && bus.WE;
    assign wr_word = bus.ADDR[AW-1:0];
    assign rd_word = rd_addr[AW-1:0];

    // A fresh request or a moved address restarts the wait-state count at 1.
    always_comb begin
        lat_nxt = 3'd1;
        if (lat_cnt != 3'd0 && bus.ADDR == rd_addr) begin
            lat_nxt = (lat_cnt == LAT) ? LAT : lat_cnt + 3'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= LOAD;
            load_ptr     <= '0;
            lat_cnt      <= 3'd0;
            rd_addr      <= 20'd0;
            rd_valid_r   <= 1'b0;
            load_ready_r <= 1'b1;
            load_ovf_r   <= 1'b0;
            serving_r    <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.load_valid) begin
                        load_ptr <= load_ptr + 1'b1;
                        if (&load_ptr) begin
                            load_ovf_r <= 1'b1;
                        end
                        if (bus.load_last) begin
                            state        <= SERVE;
                            load_ready_r <= 1'b0;
                            serving_r    <= 1'b1;
                        end
                    end
                end
                SERVE: begin
                    if (wr_req) begin
                        rd_valid_r <= 1'b0;
                        lat_cnt    <= 3'd0;
                    end else if (rd_req) begin
                        rd_addr    <= bus.ADDR;
                        lat_cnt    <= lat_nxt;
                        rd_valid_r <= (lat_nxt == LAT);
                    end else begin
                        rd_valid_r <= 1'b0;
                        lat_cnt    <= 3'd0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Array is deliberately left out of reset; only loader beats and bus writes change it.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (state == LOAD && bus.load_valid) begin
                mem[load_ptr] <= bus.load_data;
            end else if (state == SERVE && wr_req) begin
                if (!bus.UB) begin
                    mem[wr_word][15:8] <= bus.Data[15:8];
                end
                if (!bus.LB) begin
                    mem[wr_word][7:0] <= bus.Data[7:0];
                end
            end
        end
    end

    assign rd_word_data = mem[rd_word];
    assign bus.rsp_data = {bus.UB ? 8'h00 : rd_word_data[15:8],
                           bus.LB ? 8'h00 : rd_word_data[7:0]};
    // Gating with WE keeps the responder off the bus whenever the CPU may be driving it.
    assign bus.rsp_oe     = rd_valid_r && bus.WE;
    assign bus.rd_valid   = rd_valid_r;
    assign bus.load_ready = load_ready_r;
    assign bus.load_ovf   = load_ovf_r;
    assign bus.serving    = serving_r;
endmodule
